pursuit_controller: RTL and testbench

PURSUIT_CONTROLLER -- requirements
Module: pursuit_controller

---
 rtl/pursuit_controller.sv | 172 +++++++++++++++++
 tb/tb_pursuit_controller.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pursuit_controller.sv
// Target-following steering controller: IR enable/distance control, zone steering,
// debounced drive-state changes, lost-target timeout and pixel-area speed multiplier.
module pursuit_controller #(
  parameter int DIR_W            = 5,
  parameter int DIST_W           = 8,
  parameter int PIX_W            = 17,
  parameter int FAST_LEFT_BOUND  = 3,
  parameter int LEFT_BOUND       = 8,
  parameter int RIGHT_BOUND      = 15,
  parameter int FAST_RIGHT_BOUND = 20,
  parameter int DEFAULT_DISTANCE = 20,
  parameter int MIN_DISTANCE     = 20,
  parameter int MAX_DISTANCE     = 100,
  parameter int DIST_STEP        = 10,
  parameter int HOLD_CYCLES      = 4,
  parameter int LOST_TIMEOUT     = 1000,
  parameter int PIX_T1           = 5000,
  parameter int PIX_T2           = 15000,
  parameter logic [31:0] CMD_STOP = 32'hed126b86,
  parameter logic [31:0] CMD_GO   = 32'he9166b86,
  parameter logic [31:0] CMD_INC  = 32'he51a6b86,
  parameter logic [31:0] CMD_DEC  = 32'he11e6b86
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              no_red,
  input  logic [PIX_W-1:0]  pixel_count,
  input  logic [DIR_W-1:0]  detected_direction,
  input  logic [DIST_W-1:0] average_distance,
  input  logic [31:0]       ir_command,
  input  logic              ir_data_ready,
  output logic [2:0]        drive_command,
  output logic [DIST_W-1:0] follow_distance,
  output logic [2:0]        multiplier,
  output logic              enabled,
  output logic              valid
);

  typedef enum logic [2:0] {
    ST_STOP       = 3'd0,
    ST_FAST_LEFT  = 3'd1,
    ST_LEFT       = 3'd2,
    ST_STRAIGHT   = 3'd3,
    ST_RIGHT      = 3'd4,
    ST_FAST_RIGHT = 3'd5
  } drive_t;

  localparam int LOST_W = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT + 1) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int EXT_W  = DIST_W + 1;

  localparam logic [DIR_W-1:0]  FL_B     = DIR_W'(FAST_LEFT_BOUND);
  localparam logic [DIR_W-1:0]  L_B      = DIR_W'(LEFT_BOUND);
  localparam logic [DIR_W-1:0]  R_B      = DIR_W'(RIGHT_BOUND);
  localparam logic [DIR_W-1:0]  FR_B     = DIR_W'(FAST_RIGHT_BOUND);
  localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
  localparam logic [EXT_W-1:0]  STEP_E   = EXT_W'(DIST_STEP);
  localparam logic [EXT_W-1:0]  MIN_E    = EXT_W'(MIN_DISTANCE);
  localparam logic [EXT_W-1:0]  MAX_E    = EXT_W'(MAX_DISTANCE);
  localparam logic [DIST_W-1:0] DEF_D    = DIST_W'(DEFAULT_DISTANCE);
  localparam logic [PIX_W-1:0]  T1_P     = PIX_W'(PIX_T1);
  localparam logic [PIX_W-1:0]  T2_P     = PIX_W'(PIX_T2);

  drive_t              state, state_nxt, pending, pending_nxt, zone, candidate;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt, hold_inc;
  logic [LOST_W-1:0]   lost_cnt, lost_nxt;
  logic                too_close, enabled_nxt, valid_pre;
  logic [DIST_W-1:0]   fd_nxt;
  logic [EXT_W-1:0]    fd_ext, fd_inc, fd_sub;
  logic [2:0]          mult_nxt;

  // Steering zone from the target's horizontal position.
  always_comb begin
    zone = ST_STRAIGHT;
    if (detected_direction < FL_B)      zone = ST_FAST_LEFT;
    else if (detected_direction < L_B)  zone = ST_LEFT;
    else if (detected_direction > FR_B) zone = ST_FAST_RIGHT;
    else if (detected_direction > R_B)  zone = ST_RIGHT;
  end

  // While the target is briefly out of view the vehicle keeps its current course.
  always_comb begin
    candidate = zone;
    if (!enabled || too_close || (lost_cnt == LOST_MAX)) candidate = ST_STOP;
    else if (no_red)                                     candidate = state;
  end

  // Stop is immediate; any other change must be requested HOLD_CYCLES times in a row.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    hold_nxt    = hold_cnt;
    hold_inc    = (candidate != pending) ? HOLD_ONE : hold_cnt + HOLD_ONE;
    if (candidate == ST_STOP) begin
      state_nxt   = ST_STOP;
      pending_nxt = ST_STOP;
      hold_nxt    = '0;
    end else if (candidate == state) begin
      hold_nxt = '0;
    end else begin
      pending_nxt = candidate;
      if (hold_inc >= HOLD_MAX) begin
        state_nxt = candidate;
        hold_nxt  = '0;
      end else begin
        hold_nxt = hold_inc;
      end
    end
  end

  always_comb begin
    lost_nxt = '0;
    if (no_red) lost_nxt = (lost_cnt == LOST_MAX) ? LOST_MAX : lost_cnt + LOST_W'(1);
  end

  // IR: ir_command is meaningful only in the cycle ir_data_ready is high; there is
  // no back-pressure, each qualified word is consumed at the following edge.
  assign fd_ext = EXT_W'(follow_distance);
  assign fd_inc = fd_ext + STEP_E;
  assign fd_sub = fd_ext - STEP_E;

  always_comb begin
    enabled_nxt = enabled;
    fd_nxt      = follow_distance;
    if (ir_data_ready) begin
      if (ir_command == CMD_STOP)     enabled_nxt = 1'b0;
      else if (ir_command == CMD_GO)  enabled_nxt = 1'b1;
      else if (ir_command == CMD_INC)
        fd_nxt = (fd_inc > MAX_E) ? MAX_E[DIST_W-1:0] : fd_inc[DIST_W-1:0];
      else if (ir_command == CMD_DEC)
        fd_nxt = ((fd_ext < STEP_E) || (fd_sub < MIN_E)) ? MIN_E[DIST_W-1:0]
                                                        : fd_sub[DIST_W-1:0];
    end
  end

  always_comb begin
    mult_nxt = 3'd1;
    if (pixel_count > T2_P)      mult_nxt = 3'd3;
    else if (pixel_count > T1_P) mult_nxt = 3'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_STOP;
      pending         <= ST_STOP;
      hold_cnt        <= '0;
      lost_cnt        <= '0;
      too_close       <= 1'b0;
      enabled         <= 1'b0;
      follow_distance <= DEF_D;
      multiplier      <= 3'd1;
      valid_pre       <= 1'b0;
      valid           <= 1'b0;
    end else begin
      state           <= state_nxt;
      pending         <= pending_nxt;
      hold_cnt        <= hold_nxt;
      lost_cnt        <= lost_nxt;
      too_close       <= (average_distance < follow_distance);
      enabled         <= enabled_nxt;
      follow_distance <= fd_nxt;
      multiplier      <= mult_nxt;
      valid_pre       <= 1'b1;
      valid           <= valid_pre;
    end
  end

  assign drive_command = state;

endmodule

// File: tb/tb_pursuit_controller.sv
// Bench for pursuit_controller: directed sequences, a stimulus table and a
// randomized run, all scored against a behavioural model of the controller.
module tb_pursuit_controller;

  localparam logic [31:0] CMD_STOP = 32'hed126b86;
  localparam logic [31:0] CMD_GO   = 32'he9166b86;
  localparam logic [31:0] CMD_INC  = 32'he51a6b86;
  localparam logic [31:0] CMD_DEC  = 32'he11e6b86;
  localparam int LOST = 1000;
  localparam int HOLD = 4;

  // clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        no_red = 1'b0;
  logic [16:0] pixel_count = '0;
  logic [4:0]  detected_direction = 5'd11;
  logic [7:0]  average_distance = 8'd200;
  logic [31:0] ir_command = '0;
  logic        ir_data_ready = 1'b0;
  logic [2:0]  drive_command, multiplier;
  logic [7:0]  follow_distance;
  logic        enabled, valid;

  always #5 clk = ~clk;

  pursuit_controller dut (
    .clk(clk), .reset(reset), .no_red(no_red), .pixel_count(pixel_count),
    .detected_direction(detected_direction), .average_distance(average_distance),
    .ir_command(ir_command), .ir_data_ready(ir_data_ready),
    .drive_command(drive_command), .follow_distance(follow_distance),
    .multiplier(multiplier), .enabled(enabled), .valid(valid)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model
  int m_state, m_pending, m_cnt, m_en, m_tc, m_lost, m_fd, m_mult, m_age;

  function automatic int zone_of(input int d);
    if (d < 3)  return 1;
    if (d < 8)  return 2;
    if (d > 20) return 5;
    if (d > 15) return 4;
    return 3;
  endfunction

  task automatic model_step();
    int cand;
    if (reset) begin
      m_state = 0; m_pending = 0; m_cnt = 0; m_en = 0; m_tc = 0;
      m_lost = 0; m_fd = 20; m_mult = 1; m_age = 0;
    end else begin
      if (m_en == 0 || m_tc == 1 || m_lost == LOST) cand = 0;
      else if (no_red)                              cand = m_state;
      else                                          cand = zone_of(int'(detected_direction));
      if (cand == 0) begin
        m_state = 0; m_pending = 0; m_cnt = 0;
      end else if (cand == m_state) begin
        m_cnt = 0;
      end else begin
        if (cand != m_pending) begin
          m_pending = cand;
          m_cnt = 1;
        end else begin
          m_cnt++;
        end
        if (m_cnt >= HOLD) begin
          m_state = cand;
          m_cnt = 0;
        end
      end
      m_tc   = (int'(average_distance) < m_fd) ? 1 : 0;
      m_lost = no_red ? ((m_lost + 1 > LOST) ? LOST : m_lost + 1) : 0;
      if (ir_data_ready) begin
        if (ir_command == CMD_STOP)     m_en = 0;
        else if (ir_command == CMD_GO)  m_en = 1;
        else if (ir_command == CMD_INC) m_fd = (m_fd + 10 > 100) ? 100 : m_fd + 10;
        else if (ir_command == CMD_DEC) m_fd = (m_fd - 10 < 20) ? 20 : m_fd - 10;
      end
      m_mult = (pixel_count > 15000) ? 3 : (pixel_count > 5000) ? 2 : 1;
      m_age++;
    end
  endtask

  task automatic compare_model();
    check("model_drive", 32'(drive_command), m_state);
    check("model_fd", 32'(follow_distance), m_fd);
    check("model_mult", 32'(multiplier), m_mult);
    check("model_enabled", 32'(enabled), m_en);
    check("model_valid", 32'(valid), (m_age >= 2) ? 1 : 0);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic send_ir(input logic [31:0] cmd);
    ir_command    = cmd;
    ir_data_ready = 1'b1;
    tick();
    ir_data_ready = 1'b0;
    ir_command    = '0;
  endtask

  typedef struct {
    logic [31:0] cmd;
    logic        rdy;
    logic [16:0] pix;
    int          exp_fd;
    int          exp_mult;
  } vec_t;

  vec_t tbl[$];
  int   inc_exp[10] = '{30, 40, 50, 60, 70, 80, 90, 100, 100, 100};
  int   dec_exp[10] = '{90, 80, 70, 60, 50, 40, 30, 20, 20, 20};
  logic [31:0] cmd_pool[5];

  initial begin
    for (int i = 0; i < 10; i++) tbl.push_back('{CMD_INC, 1'b1, 17'd0, inc_exp[i], 1});
    tbl.push_back('{CMD_INC, 1'b0, 17'd0, 100, 1});
    tbl.push_back('{32'h12345678, 1'b1, 17'd0, 100, 1});
    for (int i = 0; i < 10; i++) tbl.push_back('{CMD_DEC, 1'b1, 17'd0, dec_exp[i], 1});
    tbl.push_back('{32'h0, 1'b0, 17'd5000, 20, 1});
    tbl.push_back('{32'h0, 1'b0, 17'd5001, 20, 2});
    tbl.push_back('{32'h0, 1'b0, 17'd15000, 20, 2});
    tbl.push_back('{32'h0, 1'b0, 17'd15001, 20, 3});
    tbl.push_back('{32'h0, 1'b0, 17'd0, 20, 1});
    cmd_pool = '{CMD_GO, CMD_STOP, CMD_INC, CMD_DEC, 32'hdeadbeef};

    // reset state and valid timing
    repeat (2) tick();
    check("rst_drive", 32'(drive_command), 0);
    check("rst_fd", 32'(follow_distance), 20);
    check("rst_mult", 32'(multiplier), 1);
    check("rst_enabled", 32'(enabled), 0);
    check("rst_valid", 32'(valid), 0);
    reset = 1'b0;
    tick();
    check("valid_first_edge", 32'(valid), 0);
    tick();
    check("valid_second_edge", 32'(valid), 1);

    // GO then Straight after exactly four edges
    send_ir(CMD_GO);
    check("go_enabled", 32'(enabled), 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("go_latency", 32'(drive_command), (k == 4) ? 3 : 0);
    end

    // held Fast_left request, then a glitching one
    detected_direction = 5'd1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("fast_left_hold", 32'(drive_command), (k == 4) ? 1 : 3);
    end
    detected_direction = 5'd11;
    repeat (4) tick();
    check("back_straight", 32'(drive_command), 3);
    for (int k = 0; k < 16; k++) begin
      detected_direction = ((k / 2) % 2 == 0) ? 5'd1 : 5'd11;
      tick();
      check("alt_glitch", 32'(drive_command), 3);
    end

    // coast in Left, lost timeout, resume
    detected_direction = 5'd5;
    repeat (4) tick();
    check("left", 32'(drive_command), 2);
    no_red = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      if (k >= 999) check("coast", 32'(drive_command), 2);
    end
    no_red = 1'b0;
    tick();
    check("lost_stop", 32'(drive_command), 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("lost_resume", 32'(drive_command), (k == 4) ? 2 : 0);
    end

    // table: follow distance limits and multiplier thresholds
    detected_direction = 5'd11;
    repeat (4) tick();
    check("table_pre_straight", 32'(drive_command), 3);
    foreach (tbl[i]) begin
      ir_command    = tbl[i].cmd;
      ir_data_ready = tbl[i].rdy;
      pixel_count   = tbl[i].pix;
      tick();
      check("tbl_fd", 32'(follow_distance), tbl[i].exp_fd);
      check("tbl_mult", 32'(multiplier), tbl[i].exp_mult);
    end
    ir_data_ready = 1'b0;
    pixel_count   = '0;

    // too_close is strict
    average_distance = 8'd20;
    repeat (4) tick();
    check("dist_equal_no_stop", 32'(drive_command), 3);
    average_distance = 8'd19;
    tick();
    check("dist_19_registered", 32'(drive_command), 3);
    tick();
    check("dist_19_stop", 32'(drive_command), 0);
    average_distance = 8'd200;

    // STOP command while in Fast_right
    detected_direction = 5'd25;
    repeat (8) tick();
    check("fast_right", 32'(drive_command), 5);
    send_ir(CMD_STOP);
    check("stop_enabled", 32'(enabled), 0);
    tick();
    check("stop_cmd_drive", 32'(drive_command), 0);

    // reset mid-debounce with IR ignored during reset
    send_ir(CMD_GO);
    detected_direction = 5'd11;
    repeat (8) tick();
    check("pre_reset_straight", 32'(drive_command), 3);
    detected_direction = 5'd1;
    repeat (2) tick();
    reset = 1'b1;
    ir_command = CMD_INC;
    ir_data_ready = 1'b1;
    tick();
    check("mid_reset_drive", 32'(drive_command), 0);
    check("mid_reset_fd", 32'(follow_distance), 20);
    check("mid_reset_enabled", 32'(enabled), 0);
    ir_data_ready = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    check("post_reset_idle", 32'(drive_command), 0);

    // randomized run scored by the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) no_red = ~no_red;
      if ($urandom_range(0, 5) == 0) detected_direction = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0)
        average_distance = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(60, 255))
                                                       : 8'($urandom_range(0, 110));
      case ($urandom_range(0, 5))
        0:       pixel_count = 17'd5000;
        1:       pixel_count = 17'd5001;
        2:       pixel_count = 17'd15000;
        3:       pixel_count = 17'd15001;
        default: pixel_count = 17'($urandom_range(0, 20000));
      endcase
      ir_data_ready = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 8))
        0, 1, 2: ir_command = cmd_pool[0];
        3:       ir_command = cmd_pool[1];
        4, 5:    ir_command = cmd_pool[2];
        6, 7:    ir_command = cmd_pool[3];
        default: ir_command = cmd_pool[4];
      endcase
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
